// File: rtl/taylor_coeff_sequencer.sv
// Fetches the NUM_TERMS Taylor coefficients of one function from a registered ROM,
// highest power first, and streams them through a 2-entry buffer on a valid/ready port.
module taylor_coeff_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5,
  parameter int NUM_TERMS  = 8,
  parameter int FUNC_SEL_W = 2,
  localparam int IDX_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [FUNC_SEL_W-1:0] func_sel_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_LINES-1:0] rom_addr_o,
  output logic                  rom_rd_en_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] coeff_o,
  output logic [IDX_W-1:0]      coeff_idx_o,
  output logic                  coeff_valid_o,
  output logic                  coeff_last_o,
  input  logic                  coeff_ready_i,
  output logic [1:0]            fsm_state_o
);

  // Handshake: a coefficient transfers in any cycle where coeff_valid_o and coeff_ready_i
  // are both high; coeff_o/idx/last are held while valid is high and ready is low.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_LINES-1:0] base;
  logic [ADDR_LINES-1:0] addr_q;
  logic [IDX_W:0]        issued;
  logic                  inflight;
  logic                  discard;
  logic [IDX_W-1:0]      inflight_idx;
  logic                  busy;
  logic                  done;

  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [IDX_W-1:0]      buf_idx  [2];
  logic                  buf_last [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  rd_en;
  logic                  last_issue;
  logic                  last_pop;
  logic [2:0]            occ;
  logic [IDX_W-1:0]      issue_idx;
  logic [ADDR_LINES-1:0] next_addr;

  assign pop        = (count != 2'd0) && coeff_ready_i;
  // Credits: buffered entries plus the read returning now, less what leaves this cycle.
  assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en      = (state == ST_FETCH) && (occ < 3'd2);
  assign issue_idx  = IDX_W'(NUM_TERMS - 1) - issued[IDX_W-1:0];
  assign next_addr  = base + ADDR_LINES'(issue_idx);
  assign last_issue = rd_en && (issued == (IDX_W+1)'(NUM_TERMS - 1));
  assign push       = inflight && !discard && !abort_i;
  assign last_pop   = pop && buf_last[rd_ptr];

  assign rom_rd_en_o   = rd_en;
  assign rom_addr_o    = rd_en ? next_addr : addr_q;
  assign coeff_o       = buf_data[rd_ptr];
  assign coeff_idx_o   = buf_idx[rd_ptr];
  assign coeff_last_o  = buf_last[rd_ptr];
  assign coeff_valid_o = (count != 2'd0);
  assign busy_o        = busy;
  assign done_o        = done;
  assign fsm_state_o   = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      base         <= '0;
      addr_q       <= '0;
      issued       <= '0;
      inflight     <= 1'b0;
      discard      <= 1'b0;
      inflight_idx <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_idx[i]  <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      inflight <= rd_en;
      addr_q   <= rom_addr_o;
      // A read issued during abort returns into IDLE and must not be buffered.
      discard  <= abort_i && rd_en;
      done     <= 1'b0;
      if (rd_en) inflight_idx <= issue_idx;

      if (abort_i) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              state  <= ST_FETCH;
              base   <= ADDR_LINES'(int'(func_sel_i) * NUM_TERMS);
              issued <= '0;
              busy   <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (rd_en) issued <= issued + 1'b1;
            if (last_issue) state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (last_pop) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (push) begin
          buf_data[wr_ptr] <= rom_data_i;
          buf_idx[wr_ptr]  <= inflight_idx;
          buf_last[wr_ptr] <= (inflight_idx == '0);
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_taylor_coeff_sequencer.sv
// Bench for taylor_coeff_sequencer: registered ROM model, expected-coefficient queue,
// one task per scenario.
module tb_taylor_coeff_sequencer;
  localparam int DW = 32;
  localparam int AL = 5;
  localparam int NT = 8;
  localparam int FW = 2;
  localparam int IW = 3;
  localparam int EW = DW + IW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] fsel;
  logic          abort;
  logic          ready;
  logic          busy;
  logic          done;
  logic [AL-1:0] rom_addr;
  logic          rom_rd_en;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] coeff;
  logic [IW-1:0] coeff_idx;
  logic          coeff_valid;
  logic          coeff_last;
  logic [1:0]    fsm_state;

  logic [DW-1:0] rom [32];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;
  logic [DW+AL+IW+6:0] all_out;
  int checks = 0;
  int errors = 0;

  assign obs     = {coeff, coeff_idx, coeff_last};
  assign all_out = {busy, done, rom_rd_en, rom_addr, coeff, coeff_idx, coeff_valid, coeff_last, fsm_state};

  taylor_coeff_sequencer #(
    .DATA_WIDTH(DW), .ADDR_LINES(AL), .NUM_TERMS(NT), .FUNC_SEL_W(FW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .func_sel_i(fsel), .abort_i(abort),
    .busy_o(busy), .done_o(done), .rom_addr_o(rom_addr), .rom_rd_en_o(rom_rd_en),
    .rom_data_i(rom_data), .coeff_o(coeff), .coeff_idx_o(coeff_idx),
    .coeff_valid_o(coeff_valid), .coeff_last_o(coeff_last), .coeff_ready_i(ready),
    .fsm_state_o(fsm_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd_en) rom_data <= rom[rom_addr];

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic drive(input logic s, input logic [FW-1:0] f, input logic a, input logic r);
    @(negedge clk);
    start = s; fsel = f; abort = a; ready = r;
    #1;
  endtask

  task automatic push_seq(input int f);
    logic [IW-1:0] ix;
    for (int k = 0; k < NT; k++) begin
      ix = IW'(NT - 1 - k);
      exp_q.push_back({rom[f*NT + NT-1-k], ix, (k == NT-1)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; fsel = 2'd1; abort = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    end
    @(negedge clk); rst = 1'b0; start = 1'b0; ready = 1'b0;
    drive(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || rom_rd_en !== 1'b0 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL reset_no_start: busy=%b rd_en=%b state=%0d expected 0/0/0", busy, rom_rd_en, fsm_state);
    end
  endtask

  task automatic test_nominal();
    logic [EW-1:0] e;
    drive(1, 2'd1, 0, 1);
    push_seq(1);
    for (int c = 1; c <= 12; c++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (rom_rd_en !== (c <= 8)) begin errors++; $display("FAIL nom_rd_en c=%0d: got %b expected %b", c, rom_rd_en, (c <= 8)); end
      if (c <= 8) begin
        checks++;
        if (rom_addr !== AL'(15 - (c-1))) begin errors++; $display("FAIL nom_addr c=%0d: got %0d expected %0d", c, rom_addr, 15-(c-1)); end
      end
      checks++;
      if (coeff_valid !== (c >= 3 && c <= 10)) begin errors++; $display("FAIL nom_valid c=%0d: got %b", c, coeff_valid); end
      if (coeff_valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL nom_extra_beat: got %h expected none", obs); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL nom_beat c=%0d: got %h expected %h", c, obs, e); end
        end
      end
      checks++;
      if (done !== (c == 11) || busy !== (c <= 10)) begin
        errors++; $display("FAIL nom_done_busy c=%0d: done=%b busy=%b expected %b/%b", c, done, busy, (c == 11), (c <= 10));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL nom_missing: %0d beats left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [EW-1:0] e;
    logic [EW-1:0] prev_obs = '0;
    logic [AL-1:0] prev_addr;
    logic prev_stall = 1'b0;
    logic done_seen = 1'b0;
    int issued = 0;
    int popped = 0;
    drive(1, 2'd0, 0, 0);
    push_seq(0);
    prev_addr = rom_addr;
    for (int c = 1; c < 200 && !done_seen; c++) begin
      drive(0, 0, 0, pat[c % 6] != 0);
      if (rom_rd_en) issued++;
      if (prev_stall) begin
        checks++;
        if (obs !== prev_obs) begin errors++; $display("FAIL bp_stable c=%0d: got %h expected %h", c, obs, prev_obs); end
      end
      if (!rom_rd_en) begin
        checks++;
        if (rom_addr !== prev_addr) begin errors++; $display("FAIL bp_addr_hold c=%0d: got %0d expected %0d", c, rom_addr, prev_addr); end
      end
      if (coeff_valid && ready) begin
        popped++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_beat: got %h expected none", obs); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL bp_beat c=%0d: got %h expected %h", c, obs, e); end
        end
      end
      checks++;
      if (issued - popped > 2) begin errors++; $display("FAIL bp_credit c=%0d: got %0d outstanding expected <=2", c, issued - popped); end
      done_seen  = done;
      prev_stall = coeff_valid && !ready;
      prev_obs   = obs;
      prev_addr  = rom_addr;
    end
    checks++;
    if (!done_seen || popped != NT || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_complete: done=%b popped=%0d left=%0d busy=%b expected 1/8/0/0", done_seen, popped, exp_q.size(), busy);
    end
  endtask

  task automatic test_abort();
    logic [EW-1:0] e;
    int beats = 0;
    logic done_seen = 1'b0;
    drive(1, 2'd0, 0, 1);
    push_seq(0);
    for (int c = 1; c <= 5; c++) begin
      drive(0, 0, 0, 1);
      if (coeff_valid && ready) begin
        beats++;
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL ab_pre_beat c=%0d: got %h expected %h", c, obs, e); end
      end
    end
    checks++;
    if (beats != 3) begin errors++; $display("FAIL ab_pre_count: got %0d expected 3", beats); end
    drive(0, 0, 1, 0);
    drive(1, 2'd2, 0, 1);
    exp_q.delete();
    push_seq(2);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || coeff_valid !== 1'b0) begin
      errors++; $display("FAIL ab_after: busy=%b done=%b valid=%b expected 0/0/0", busy, done, coeff_valid);
    end
    beats = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      drive(0, 0, 0, 1);
      done_seen = done;
      if (coeff_valid && ready) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ab_extra_beat: got %h expected none", obs); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL ab_restart_beat: got %h expected %h", obs, e); end
        end
      end
    end
    checks++;
    if (!done_seen || beats != NT || exp_q.size() != 0) begin
      errors++; $display("FAIL ab_restart_done: done=%b beats=%0d left=%0d expected 1/8/0", done_seen, beats, exp_q.size());
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (coeff_valid !== 1'b0) begin errors++; $display("FAIL ab_quiet c=%0d: valid=%b expected 0", c, coeff_valid); end
    end
  endtask

  task automatic test_start_busy();
    logic [EW-1:0] e;
    drive(1, 2'd0, 0, 1);
    push_seq(0);
    for (int c = 1; c <= 12; c++) begin
      drive((c == 2 || c == 9), 2'd3, 0, 1);
      if (c <= 8) begin
        checks++;
        if (rom_rd_en !== 1'b1 || rom_addr !== AL'(7 - (c-1))) begin
          errors++; $display("FAIL sb_read c=%0d: rd_en=%b addr=%0d expected 1/%0d", c, rom_rd_en, rom_addr, 7-(c-1));
        end
      end
      if (coeff_valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sb_extra_beat: got %h expected none", obs); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL sb_beat c=%0d: got %h expected %h", c, obs, e); end
        end
      end
      checks++;
      if (done !== (c == 11)) begin errors++; $display("FAIL sb_done c=%0d: got %b expected %b", c, done, (c == 11)); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_missing: %0d left expected 0", exp_q.size()); end
    drive(1, 2'd1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (busy !== 1'b0 || fsm_state !== 2'd0 || rom_rd_en !== 1'b0 || coeff_valid !== 1'b0) begin
        errors++; $display("FAIL sb_start_abort c=%0d: busy=%b state=%0d rd_en=%b valid=%b expected 0", c, busy, fsm_state, rom_rd_en, coeff_valid);
      end
    end
  endtask

  task automatic test_func3_reset();
    logic [EW-1:0] e;
    drive(1, 2'd3, 0, 1);
    push_seq(3);
    for (int c = 1; c <= 10; c++) begin
      drive(0, 0, 0, (c <= 8));
      if (c <= 8) begin
        checks++;
        if (rom_rd_en !== 1'b1 || rom_addr !== AL'(31 - (c-1))) begin
          errors++; $display("FAIL f3_read c=%0d: rd_en=%b addr=%0d expected 1/%0d", c, rom_rd_en, rom_addr, 31-(c-1));
        end
      end
      if (coeff_valid && ready) begin
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL f3_beat c=%0d: got %h expected %h", c, obs, e); end
      end
    end
    checks++;
    if (fsm_state !== 2'd2 || coeff_valid !== 1'b1) begin
      errors++; $display("FAIL f3_drain: state=%0d valid=%b expected 2/1", fsm_state, coeff_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL f3_async_reset: got %h expected 0", all_out); end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    drive(0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0 || coeff_valid !== 1'b0) begin
      errors++; $display("FAIL f3_post_reset: busy=%b valid=%b expected 0/0", busy, coeff_valid);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fsel = '0; abort = 1'b0; ready = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_func3_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
